// File: rtl/rotator_memory8.sv
// Twiddle-factor ROM for the N=8 SDF FFT stage.
// It steps W8^k (k=0..3) while S=1 and outputs unity while S=0.
module rotator_memory8 #(
    parameter int W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                S,
    output logic signed [W-1:0] rotator_real,
    output logic signed [W-1:0] rotator_img
);

    // Q2.16 constants; cos/sin(pi/4) rounded to 46341
    localparam logic signed [W-1:0] P_ONE  = W'(65536);
    localparam logic signed [W-1:0] N_ONE  = W'(-65536);
    localparam logic signed [W-1:0] P_R2   = W'(46341);
    localparam logic signed [W-1:0] N_R2   = W'(-46341);
    localparam logic signed [W-1:0] ZERO   = '0;

    logic [1:0]          k;
    logic signed [W-1:0] tab_re;
    logic signed [W-1:0] tab_im;

    always_comb begin
        tab_re = P_ONE;
        tab_im = ZERO;
        unique case (k)
            2'd0: begin
                tab_re = P_ONE;
                tab_im = ZERO;
            end
            2'd1: begin
                tab_re = P_R2;
                tab_im = N_R2;
            end
            2'd2: begin
                tab_re = ZERO;
                tab_im = N_ONE;
            end
            2'd3: begin
                tab_re = N_R2;
                tab_im = N_R2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k            <= 2'd0;
            rotator_real <= P_ONE;
            rotator_img  <= ZERO;
        end else if (S) begin
            k            <= k + 2'd1;
            rotator_real <= tab_re;
            rotator_img  <= tab_im;
        end else begin
            k            <= 2'd0;
            rotator_real <= P_ONE;
            rotator_img  <= ZERO;
        end
    end

endmodule

// File: tb/tb_rotator_memory8.sv
// Self-checking bench for rotator_memory8.
// A trig-based model predicts every output; literals pin the key sequences.
module tb_rotator_memory8;

    localparam real PI = 3.14159265358979323846;

    logic                clk;
    logic                rst;
    logic                S;
    logic signed [17:0]  rotator_real;
    logic signed [17:0]  rotator_img;

    int checks = 0;
    int errors = 0;

    rotator_memory8 #(.W(18)) dut (
        .clk          (clk),
        .rst          (rst),
        .S            (S),
        .rotator_real (rotator_real),
        .rotator_img  (rotator_img)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rnd(real x);
        return int'($floor(x + 0.5));
    endfunction

    function automatic int w_re(int k);
        return rnd(65536.0 * $cos(2.0 * PI * k / 8.0));
    endfunction

    function automatic int w_im(int k);
        return -rnd(65536.0 * $sin(2.0 * PI * k / 8.0));
    endfunction

    task automatic check(string name, logic signed [17:0] act, int exp);
        logic signed [17:0] e;
        e = 18'(exp);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, e);
        end
    endtask

    // Model: position in the current run of S=1 edges picks the rotator
    int  run    = 0;
    bit  mvalid = 0;
    int  exp_re = 65536;
    int  exp_im = 0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            run    = 0;
            mvalid = 1;
            exp_re = 65536;
            exp_im = 0;
        end else if (S === 1'b1) begin
            exp_re = w_re(run % 4);
            exp_im = w_im(run % 4);
            run++;
        end else begin
            run    = 0;
            exp_re = 65536;
            exp_im = 0;
        end
        #1;
        if (mvalid) begin
            check("model_real", rotator_real, exp_re);
            check("model_img", rotator_img, exp_im);
        end
    end

    task automatic cyc(input logic r, input logic s);
        @(negedge clk);
        rst = r;
        S   = s;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(string name, int re, int im);
        check({name, "_real"}, rotator_real, re);
        check({name, "_img"}, rotator_img, im);
    endtask

    initial begin
        rst = 1'b1;
        S   = 1'b0;
        // 1: reset
        cyc(1, 0);
        cyc(1, 0);
        lit("reset", 65536, 0);
        // 2: pass mode
        for (int i = 0; i < 4; i++) cyc(0, 0);
        lit("pass", 65536, 0);
        // 3: one full rotation
        cyc(0, 1); lit("k0", 65536, 0);
        cyc(0, 1); lit("k1", 46341, -46341);
        cyc(0, 1); lit("k2", 0, -65536);
        cyc(0, 1); lit("k3", -46341, -46341);
        // 4: alternating windows
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cyc(0, 0);
            lit("alt_unity", 65536, 0);
            for (int i = 0; i < 4; i++) cyc(0, 1);
            lit("alt_k3", -46341, -46341);
        end
        // 5: wrap after 4
        cyc(0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1);
        cyc(0, 1); lit("wrap_k0", 65536, 0);
        cyc(0, 1); lit("wrap_k1", 46341, -46341);
        // 6: reset mid-run has priority over S
        cyc(0, 0);
        cyc(0, 1); lit("mid_k0", 65536, 0);
        cyc(0, 1); lit("mid_k1", 46341, -46341);
        cyc(1, 1); lit("mid_rst", 65536, 0);
        cyc(0, 1); lit("post_k0", 65536, 0);
        cyc(0, 1); lit("post_k1", 46341, -46341);
        // truncated run then restart
        cyc(0, 0);
        cyc(0, 1); lit("trunc_k0", 65536, 0);
        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic s;
            r = ($urandom_range(0, 40) == 0);
            s = ($urandom_range(0, 99) < 70);
            cyc(r, s);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
